// File: rtl/llsc_ctrl_pkg.sv
// Shared definitions for the LL/SC reservation controller: state encoding,
// reset/write-enable levels and the default reservation lifetime.
package llsc_ctrl_pkg;

    typedef enum logic [1:0] {
        LLSC_IDLE    = 2'd0,   // no reservation held
        LLSC_RSV     = 2'd1,   // reservation held, timer running
        LLSC_SC_WAIT = 2'd2    // successful SC store issued, waiting for mem_ack
    } llsc_state_t;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

    // Default number of cycles a reservation survives without a new LL.
    localparam int unsigned LLSC_TIMEOUT = 1023;

    // Width of a counter able to hold the value 'timeout' (never below 1 bit).
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/llsc_rsv_timer.sv
// Reservation lifetime counter. Loaded on LL, decremented while the
// reservation is held; 'expired' flags the cycle whose decrement reaches 0.
// A timeout of 0 loads 0 and never expires.
module llsc_rsv_timer
    import llsc_ctrl_pkg::*;
#(
    parameter int unsigned RSV_TIMEOUT = LLSC_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int unsigned     TW       = timer_width(RSV_TIMEOUT);
    localparam logic [TW-1:0]   LOAD_VAL = TW'(RSV_TIMEOUT);

    logic [TW-1:0] count_reg;
    logic [TW-1:0] count_next;

    // Next count: clear wins over load, load over decrement; saturate at 0.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = LOAD_VAL;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - TW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (RSV_TIMEOUT != 0) && (count_reg == TW'(1));

endmodule

// File: rtl/llsc_ctrl.sv
// LL/SC reservation controller. Tracks one word-granular reservation,
// resolves SC success, issues the SC store and drives the LLbit register.
// Per-cycle priority: rst > flush > snoop hit > sc_req > ll_req > timeout.
// Every output is registered, so results appear the cycle after the event.
module llsc_ctrl
    import llsc_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          LINE_LSB    = 2,
    parameter int unsigned RSV_TIMEOUT = LLSC_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ll_req,
    input  logic [ADDR_W-1:0] ll_addr,
    input  logic              sc_req,
    input  logic [ADDR_W-1:0] sc_addr,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic              flush,
    input  logic              mem_ack,
    output logic              sc_mem_we,
    output logic              sc_busy,
    output logic              sc_done,
    output logic              sc_ok,
    output logic              llbit_we,
    output logic              llbit_wdata
);

    // Only bits above LINE_LSB take part in address comparison.
    localparam logic [ADDR_W-1:0] CMP_MASK = {ADDR_W{1'b1}} << LINE_LSB;

    function automatic logic addr_match(input logic [ADDR_W-1:0] a,
                                        input logic [ADDR_W-1:0] b);
        return ((a ^ b) & CMP_MASK) == '0;
    endfunction

    llsc_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] rsv_addr_reg, rsv_addr_next;
    logic              suppress_reg, suppress_next;
    logic              sc_mem_we_reg, sc_mem_we_next;
    logic              sc_done_reg, sc_done_next;
    logic              sc_ok_reg, sc_ok_next;
    logic              llbit_we_reg, llbit_we_next;
    logic              llbit_wdata_reg, llbit_wdata_next;

    logic tmr_clear, tmr_load, tmr_dec, tmr_expired;
    logic snoop_hit;

    assign snoop_hit = snoop_we && addr_match(snoop_addr, rsv_addr_reg);

    llsc_rsv_timer #(
        .RSV_TIMEOUT (RSV_TIMEOUT)
    ) u_rsv_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .load    (tmr_load),
        .dec     (tmr_dec),
        .expired (tmr_expired)
    );

    // Next-state and next-output logic; outputs default to idle (no pulses).
    always_comb begin
        state_next       = state_reg;
        rsv_addr_next    = rsv_addr_reg;
        suppress_next    = suppress_reg;
        sc_mem_we_next   = 1'b0;
        sc_done_next     = 1'b0;
        sc_ok_next       = 1'b0;
        llbit_we_next    = 1'b0;
        llbit_wdata_next = 1'b0;
        tmr_clear        = 1'b0;
        tmr_load         = 1'b0;
        tmr_dec          = 1'b0;

        case (state_reg)
            LLSC_IDLE: begin
                if (flush) begin
                    // Coincident LL/SC is discarded.
                end else if (sc_req) begin
                    sc_done_next = 1'b1;
                end else if (ll_req) begin
                    state_next       = LLSC_RSV;
                    rsv_addr_next    = ll_addr;
                    tmr_load         = 1'b1;
                    llbit_we_next    = WRITE_ENABLE;
                    llbit_wdata_next = 1'b1;
                end
            end

            LLSC_RSV: begin
                if (flush) begin
                    // LLbit register clears itself on flush: no write here.
                    state_next = LLSC_IDLE;
                    tmr_clear  = 1'b1;
                end else if (snoop_hit) begin
                    state_next    = LLSC_IDLE;
                    tmr_clear     = 1'b1;
                    llbit_we_next = WRITE_ENABLE;
                    sc_done_next  = sc_req;
                end else if (sc_req) begin
                    tmr_clear = 1'b1;
                    if (addr_match(sc_addr, rsv_addr_reg)) begin
                        state_next     = LLSC_SC_WAIT;
                        sc_mem_we_next = 1'b1;
                    end else begin
                        state_next    = LLSC_IDLE;
                        sc_done_next  = 1'b1;
                        llbit_we_next = WRITE_ENABLE;
                    end
                end else if (ll_req) begin
                    rsv_addr_next    = ll_addr;
                    tmr_load         = 1'b1;
                    llbit_we_next    = WRITE_ENABLE;
                    llbit_wdata_next = 1'b1;
                end else if (tmr_expired) begin
                    state_next    = LLSC_IDLE;
                    tmr_clear     = 1'b1;
                    llbit_we_next = WRITE_ENABLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            LLSC_SC_WAIT: begin
                // The store is committed: only flush (to suppress the result)
                // and mem_ack matter here.
                if (mem_ack) begin
                    state_next    = LLSC_IDLE;
                    suppress_next = 1'b0;
                    sc_done_next  = !(suppress_reg || flush);
                    sc_ok_next    = !(suppress_reg || flush);
                    llbit_we_next = WRITE_ENABLE;
                end else begin
                    sc_mem_we_next = 1'b1;
                    if (flush) begin
                        suppress_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = LLSC_IDLE;
                tmr_clear  = 1'b1;
            end
        endcase
    end

    // State, reservation and registered outputs; reset abandons any store.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_reg       <= LLSC_IDLE;
            rsv_addr_reg    <= '0;
            suppress_reg    <= 1'b0;
            sc_mem_we_reg   <= 1'b0;
            sc_done_reg     <= 1'b0;
            sc_ok_reg       <= 1'b0;
            llbit_we_reg    <= 1'b0;
            llbit_wdata_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rsv_addr_reg    <= rsv_addr_next;
            suppress_reg    <= suppress_next;
            sc_mem_we_reg   <= sc_mem_we_next;
            sc_done_reg     <= sc_done_next;
            sc_ok_reg       <= sc_ok_next;
            llbit_we_reg    <= llbit_we_next;
            llbit_wdata_reg <= llbit_wdata_next;
        end
    end

    assign sc_mem_we   = sc_mem_we_reg;
    assign sc_busy     = sc_mem_we_reg;
    assign sc_done     = sc_done_reg;
    assign sc_ok       = sc_ok_reg;
    assign llbit_we    = llbit_we_reg;
    assign llbit_wdata = llbit_wdata_reg;

endmodule

// File: doc/llsc_ctrl.md
LLSC_CTRL -- requirements
Module: llsc_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter LINE_LSB, default 2, lowest address bit compared (word granularity).
REQ-003 Parameter RSV_TIMEOUT, default 1023, cycles a reservation may live; 0 disables timeout.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ll_req  in  1  LL instruction at MEM stage, ll_addr valid.
REQ-007 ll_addr  in  ADDR_W  LL effective address.
REQ-008 sc_req  in  1  SC instruction at MEM stage, sc_addr valid.
REQ-009 sc_addr  in  ADDR_W  SC effective address.
REQ-010 snoop_we  in  1  store by another master or DMA.
REQ-011 snoop_addr  in  ADDR_W  snooped store address.
REQ-012 flush  in  1  exception or ERET pipeline flush.
REQ-013 mem_ack  in  1  data memory accepted SC store.
REQ-014 sc_mem_we  out  1  SC store request to data memory.
REQ-015 sc_busy  out  1  pipeline stall while SC store is outstanding.
REQ-016 sc_done  out  1  one-cycle pulse, SC result valid.
REQ-017 sc_ok  out  1  SC result (1 = success), valid only with sc_done.
REQ-018 llbit_we  out  1  write enable to LLbit register.
REQ-019 llbit_wdata  out  1  write data to LLbit register.

Function
REQ-020 States IDLE (no reservation), RSV (reservation held), SC_WAIT (SC store outstanding).
REQ-021 Address match SHALL compare bits [ADDR_W-1:LINE_LSB] only.
REQ-022 Event priority each cycle SHALL be: rst > flush > snoop hit > sc_req > ll_req > timeout expiry.
REQ-023 IDLE + ll_req -> RSV; capture ll_addr, load timer, next cycle llbit_we=1, llbit_wdata=1.
REQ-024 IDLE + sc_req -> stay IDLE; next cycle sc_done=1, sc_ok=0; no store issued.
REQ-025 RSV + ll_req (no higher event) -> stay RSV; recapture address, reload timer; llbit_we=1, llbit_wdata=1 next cycle.
REQ-026 RSV + sc_req, address match -> SC_WAIT; sc_mem_we and sc_busy asserted from next cycle until mem_ack sampled high.
REQ-027 RSV + sc_req, address mismatch -> IDLE; next cycle sc_done=1, sc_ok=0, llbit_we=1, llbit_wdata=0.
REQ-028 RSV + snoop_we with address match -> IDLE; next cycle llbit_we=1, llbit_wdata=0; simultaneous sc_req fails as REQ-027 (sc_done=1, sc_ok=0).
REQ-029 RSV timer decrements once per cycle; reaching 0 -> IDLE, llbit_we=1, llbit_wdata=0.
REQ-030 SC_WAIT + mem_ack -> IDLE; next cycle sc_mem_we=0, sc_busy=0, sc_done=1, sc_ok=1, llbit_we=1, llbit_wdata=0.
REQ-031 SC_WAIT ignores snoop_we, ll_req, sc_req and timeout; the store is committed.
REQ-032 flush in IDLE/RSV -> IDLE, reservation cleared, no llbit_we pulse (LLbit register clears itself on flush); a coincident sc_req/ll_req is discarded, no sc_done.
REQ-033 flush in SC_WAIT SHALL NOT abort the bus store; set a suppress flag, keep waiting for mem_ack, then go IDLE with sc_done suppressed and llbit_we=1, llbit_wdata=0.
REQ-034 All outputs SHALL be registered; sc_done and llbit_we are single-cycle pulses.

Reset
REQ-035 rst SHALL force IDLE, reservation valid=0, address=0, timer=0, suppress flag=0.
REQ-036 During and the cycle after rst all outputs SHALL be 0; rst mid-SC_WAIT abandons the store with no sc_done.

Structure
REQ-037 State encodings and LLSC_TIMEOUT default SHALL live in the shared define.v alongside RstEnable/WriteEnable.
REQ-038 The reservation timer SHALL be one sub-module, llsc_rsv_timer (load, decrement, expired flag).

Verification
REQ-039 LL 0x100, SC 0x100 two cycles later, mem_ack after 3 cycles -> sc_busy 3 cycles, sc_done=1, sc_ok=1, llbit cleared.
REQ-040 LL 0x100, SC 0x104 -> sc_done=1, sc_ok=0, no sc_mem_we; LL 0x100, SC 0x102 -> success (same word).
REQ-041 LL 0x200, snoop store 0x200 same cycle as SC 0x200 -> sc_ok=0, llbit_wdata=0.
REQ-042 RSV_TIMEOUT=4: LL 0x300, wait 5 cycles, SC 0x300 -> llbit cleared at expiry, SC fails.
REQ-043 LL, SC match, flush while SC_WAIT, mem_ack 2 cycles later -> no sc_done, IDLE, llbit_we pulse with 0.
REQ-044 rst asserted in SC_WAIT -> all outputs 0 next cycle, state IDLE, later SC fails.
